// File: rtl/enet_nios_interval_timer_if.sv
// Avalon register-slave bus of the interval timer: CPU-side strobes and
// registered read data plus the level interrupt back to the CPU.
interface enet_nios_interval_timer_if;
    // Handshake: a cycle with chipselect & !write_n is a write that is always
    // accepted (no wait states); a cycle with chipselect & !read_n is a read
    // whose readdata becomes valid after the next rising clk and holds until
    // the next read.
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/enet_nios_interval_timer.sv
// Interval timer: 32-bit down-counter with reload, snapshot and a level
// interrupt, programmed through a 16-bit register window.
module enet_nios_interval_timer #(
    parameter int                     COUNTER_WIDTH  = 32,
    parameter logic [COUNTER_WIDTH-1:0] DEFAULT_PERIOD = 32'h0000_FFFF,
    parameter bit                     DEFAULT_CONT   = 1'b0
) (
    input  logic                        clk,
    input  logic                        aclr,
    enet_nios_interval_timer_if.slave   bus,
    output logic [0:0]                  state_dbg
);

    localparam logic [0:0] STOPPED = 1'b0;
    localparam logic [0:0] RUNNING = 1'b1;

    localparam logic [2:0] A_STATUS  = 3'd0;
    localparam logic [2:0] A_CONTROL = 3'd1;
    localparam logic [2:0] A_PERIODL = 3'd2;
    localparam logic [2:0] A_PERIODH = 3'd3;
    localparam logic [2:0] A_SNAPL   = 3'd4;
    localparam logic [2:0] A_SNAPH   = 3'd5;

    logic [0:0]               state;
    logic [COUNTER_WIDTH-1:0] counter;
    logic [COUNTER_WIDTH-1:0] period;
    logic [COUNTER_WIDTH-1:0] period_next;
    logic [COUNTER_WIDTH-1:0] snap;
    logic                     to;
    logic                     ito;
    logic                     cont;
    logic [15:0]              readdata_q;

    logic wr, rd;
    logic wr_status, wr_control, wr_periodl, wr_periodh, wr_period, wr_snap;
    logic running, timeout;

    assign wr         = bus.chipselect & ~bus.write_n;
    assign rd         = bus.chipselect & ~bus.read_n;
    assign wr_status  = wr && (bus.address == A_STATUS);
    assign wr_control = wr && (bus.address == A_CONTROL);
    assign wr_periodl = wr && (bus.address == A_PERIODL);
    assign wr_periodh = wr && (bus.address == A_PERIODH);
    assign wr_period  = wr_periodl | wr_periodh;
    assign wr_snap    = wr && ((bus.address == A_SNAPL) || (bus.address == A_SNAPH));

    assign running = (state == RUNNING);
    assign timeout = running && (counter == '0);

    always_comb begin
        period_next = period;
        if (wr_periodl) period_next[15:0]               = bus.writedata;
        if (wr_periodh) period_next[COUNTER_WIDTH-1:16] = bus.writedata;
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state      <= STOPPED;
            counter    <= DEFAULT_PERIOD;
            period     <= DEFAULT_PERIOD;
            snap       <= '0;
            to         <= 1'b0;
            ito        <= 1'b0;
            cont       <= DEFAULT_CONT;
            readdata_q <= '0;
        end else begin
            period <= period_next;

            // A period write restarts the count from the new value and parks the timer.
            if (wr_period)
                counter <= period_next;
            else if (timeout)
                counter <= period;
            else if (running)
                counter <= counter - 1'b1;

            // Timeout beats a coincident status clear.
            if (timeout)
                to <= 1'b1;
            else if (wr_status)
                to <= 1'b0;

            if (wr_control) begin
                ito  <= bus.writedata[0];
                cont <= bus.writedata[1];
            end

            // STOP (or a period write) dominates START; START only acts when stopped.
            if (wr_period || (wr_control && bus.writedata[3]))
                state <= STOPPED;
            else if (timeout && !cont)
                state <= STOPPED;
            else if (wr_control && bus.writedata[2] && !running)
                state <= RUNNING;

            if (wr_snap)
                snap <= counter;

            if (rd) begin
                case (bus.address)
                    A_STATUS:  readdata_q <= {14'd0, running, to};
                    A_CONTROL: readdata_q <= {14'd0, cont, ito};
                    A_PERIODL: readdata_q <= period[15:0];
                    A_PERIODH: readdata_q <= period[COUNTER_WIDTH-1:16];
                    A_SNAPL:   readdata_q <= snap[15:0];
                    A_SNAPH:   readdata_q <= snap[COUNTER_WIDTH-1:16];
                    default:   readdata_q <= '0;
                endcase
            end
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = to & ito;
    assign state_dbg    = state;

endmodule
